// File: rtl/kronos_fetch.sv
// kronos_fetch: instruction fetch stage.
//
// Issues word-aligned requests on the instruction bus, buffers responses in an
// output register plus a one-entry skid buffer, and redirects on branch.
//
// Handshakes:
//   * Instruction bus: a request is open while instr_req=1. instr_req and
//     instr_addr are held unchanged until the cycle instr_ack=1. That cycle
//     completes the request, so a zero-wait bus can ack in the same cycle the
//     request first appears.
//   * Decode side: an instruction transfers on a rising edge where both
//     fetch_vld=1 and fetch_rdy=1. While fetch_vld=1 and fetch_rdy=0, the
//     fetch_pc/fetch_ir pair does not change. The only exception is a branch,
//     which withdraws the presented instruction.
//
// instr_req and instr_addr come only from registers (state, pc_fetch). This
// means there is no combinational path from instr_ack or fetch_rdy to the
// bus request.
module kronos_fetch #(
    parameter logic [31:0] BOOT_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] instr_addr,
    output logic        instr_req,
    input  logic [31:0] instr_data,
    input  logic        instr_ack,
    input  logic        branch,
    input  logic [31:0] branch_target,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_ir,
    output logic        fetch_vld,
    input  logic        fetch_rdy
);

    // IDLE  : one cycle after reset before the first request.
    // FETCH : request open at pc_fetch.
    // HOLD  : output and skid both full, bus quiet until decode drains one.
    // FLUSH : a branch arrived while a request was open; wait out that
    //         request, discard its data, then resume at the redirect target.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] pc_fetch;
    logic [31:0] pc_fetch_nxt;
    // Target remembered during FLUSH; pc_fetch must keep driving the open request.
    logic [31:0] redirect_pc;
    logic [31:0] redirect_pc_nxt;

    logic [31:0] skid_pc;
    logic [31:0] skid_pc_nxt;
    logic [31:0] skid_ir;
    logic [31:0] skid_ir_nxt;
    logic        skid_vld;
    logic        skid_vld_nxt;

    logic [31:0] fetch_pc_nxt;
    logic [31:0] fetch_ir_nxt;
    logic        fetch_vld_nxt;

    logic [31:0] target_aligned;
    logic [31:0] pc_plus4;
    logic        out_free;

    // Redirects are always word aligned; low target bits are dropped.
    assign target_aligned = branch_target & ~32'd3;
    // Sequential next address; wraps from 32'hFFFF_FFFC to 0 naturally.
    assign pc_plus4       = pc_fetch + 32'd4;
    // Output register can take a new word: empty, or emptying this edge.
    assign out_free       = !fetch_vld || fetch_rdy;

    assign instr_req  = (state == FETCH) || (state == FLUSH);
    assign instr_addr = pc_fetch;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath decisions; branch outranks ack, transfer and drain.
    always_comb begin
        state_nxt       = state;
        pc_fetch_nxt    = pc_fetch;
        redirect_pc_nxt = redirect_pc;
        fetch_pc_nxt    = fetch_pc;
        fetch_ir_nxt    = fetch_ir;
        // A transfer with nothing new arriving empties the output register.
        fetch_vld_nxt   = fetch_vld && !fetch_rdy;
        skid_pc_nxt     = skid_pc;
        skid_ir_nxt     = skid_ir;
        skid_vld_nxt    = skid_vld;

        case (state)
            IDLE: begin
                // Any stray ack here belongs to a request abandoned by reset.
                state_nxt = FETCH;
            end

            FETCH: begin
                if (branch) begin
                    fetch_vld_nxt = 1'b0;
                    skid_vld_nxt  = 1'b0;
                    if (instr_ack) begin
                        // Response is dropped; the next request goes to the target.
                        pc_fetch_nxt = target_aligned;
                    end else begin
                        // The open request must run to completion untouched.
                        redirect_pc_nxt = target_aligned;
                        state_nxt       = FLUSH;
                    end
                end else if (instr_ack) begin
                    pc_fetch_nxt = pc_plus4;
                    if (out_free) begin
                        fetch_pc_nxt  = pc_fetch;
                        fetch_ir_nxt  = instr_data;
                        fetch_vld_nxt = 1'b1;
                    end else begin
                        skid_pc_nxt  = pc_fetch;
                        skid_ir_nxt  = instr_data;
                        skid_vld_nxt = 1'b1;
                        state_nxt    = HOLD;
                    end
                end
            end

            HOLD: begin
                if (branch) begin
                    fetch_vld_nxt = 1'b0;
                    skid_vld_nxt  = 1'b0;
                    pc_fetch_nxt  = target_aligned;
                    state_nxt     = FETCH;
                end else if (fetch_rdy) begin
                    // Output word leaves; skid word takes its place.
                    fetch_pc_nxt  = skid_pc;
                    fetch_ir_nxt  = skid_ir;
                    fetch_vld_nxt = 1'b1;
                    skid_vld_nxt  = 1'b0;
                    state_nxt     = FETCH;
                end
            end

            FLUSH: begin
                fetch_vld_nxt = 1'b0;
                skid_vld_nxt  = 1'b0;
                if (branch) begin
                    redirect_pc_nxt = target_aligned;
                end
                if (instr_ack) begin
                    // Data of the abandoned request is discarded.
                    pc_fetch_nxt = branch ? target_aligned : redirect_pc;
                    state_nxt    = FETCH;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath registers: fetch address, redirect target, output register, skid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_fetch    <= BOOT_ADDR;
            redirect_pc <= 32'h0;
            fetch_pc    <= 32'h0;
            fetch_ir    <= 32'h0;
            fetch_vld   <= 1'b0;
            skid_pc     <= 32'h0;
            skid_ir     <= 32'h0;
            skid_vld    <= 1'b0;
        end else begin
            pc_fetch    <= pc_fetch_nxt;
            redirect_pc <= redirect_pc_nxt;
            fetch_pc    <= fetch_pc_nxt;
            fetch_ir    <= fetch_ir_nxt;
            fetch_vld   <= fetch_vld_nxt;
            skid_pc     <= skid_pc_nxt;
            skid_ir     <= skid_ir_nxt;
            skid_vld    <= skid_vld_nxt;
        end
    end

endmodule

// File: tb/tb_kronos_fetch.sv
// Bench for kronos_fetch: directed scenarios followed by a randomized run
// checked against a transaction-level model of the fetch stream.
module tb_kronos_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_addr;
    logic        instr_req;
    logic [31:0] instr_data;
    logic        instr_ack;
    logic        branch;
    logic [31:0] branch_target;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_ir;
    logic        fetch_vld;
    logic        fetch_rdy;

    int total = 0;
    int bad   = 0;

    // Randomized-phase model state
    logic [31:0] next_req;     // address the next fresh bus request must use
    logic        redir;        // a branch happened since the last fresh request
    logic [31:0] exp_pc;       // PC the next delivered instruction must carry
    int          deliveries;
    logic        p_req, p_ack, p_vld, p_rdy, p_branch;
    logic [31:0] p_addr, p_pc, p_ir;
    logic        r_ack, r_rdy, r_br;
    logic [31:0] r_tgt;

    kronos_fetch #(.BOOT_ADDR(32'h100)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_addr    (instr_addr),
        .instr_req     (instr_req),
        .instr_data    (instr_data),
        .instr_ack     (instr_ack),
        .branch        (branch),
        .branch_target (branch_target),
        .fetch_pc      (fetch_pc),
        .fetch_ir      (fetch_ir),
        .fetch_vld     (fetch_vld),
        .fetch_rdy     (fetch_rdy)
    );

    // Clock
    always #5 clk = ~clk;

    // Time bound
    initial begin
        #400000;
        $display("FAIL timeout: observed=no_finish required=finish");
        $fatal(1, "timeout");
    end

    // Memory contents seen through the bus: a fixed function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[31:16]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a bus response for the address currently requested.
    task automatic set_bus(input logic ack);
        instr_ack  = ack;
        instr_data = ack ? mem_word(instr_addr) : 32'h0;
    endtask

    task automatic expect_bus(input string tag, input logic req, input logic [31:0] addr);
        check({tag, "_req"}, {31'd0, instr_req}, {31'd0, req});
        if (req) check({tag, "_addr"}, instr_addr, addr);
    endtask

    task automatic expect_out(input string tag, input logic vld, input logic [31:0] pc);
        check({tag, "_vld"}, {31'd0, fetch_vld}, {31'd0, vld});
        if (vld) begin
            check({tag, "_pc"}, fetch_pc, pc);
            check({tag, "_ir"}, fetch_ir, mem_word(pc));
        end
    endtask

    // Reset, release, then one edge so the block sits in FETCH at BOOT_ADDR.
    task automatic do_reset();
        rst = 1'b1;
        instr_ack = 1'b0; instr_data = 32'h0;
        branch = 1'b0; branch_target = 32'h0; fetch_rdy = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        // ---- reset values and first request ----
        rst = 1'b1;
        instr_ack = 1'b0; instr_data = 32'h0;
        branch = 1'b0; branch_target = 32'h0; fetch_rdy = 1'b0;
        step();
        check("rst_req", {31'd0, instr_req}, 32'd0);
        check("rst_vld", {31'd0, fetch_vld}, 32'd0);
        check("rst_pc", fetch_pc, 32'h0);
        check("rst_ir", fetch_ir, 32'h0);
        check("rst_addr", instr_addr, 32'h100);
        rst = 1'b0;
        #1;
        check("idle_req", {31'd0, instr_req}, 32'd0);
        step();
        expect_bus("first", 1'b1, 32'h100);
        expect_out("first", 1'b0, 32'h0);

        // ---- zero-wait streaming ----
        fetch_rdy = 1'b1;
        set_bus(1'b1); step();
        expect_bus("zw0", 1'b1, 32'h104); expect_out("zw0", 1'b1, 32'h100);
        set_bus(1'b1); step();
        expect_bus("zw1", 1'b1, 32'h108); expect_out("zw1", 1'b1, 32'h104);
        set_bus(1'b1); step();
        expect_bus("zw2", 1'b1, 32'h10C); expect_out("zw2", 1'b1, 32'h108);
        set_bus(1'b0); step();
        expect_bus("zw3", 1'b1, 32'h10C); expect_out("zw3", 1'b0, 32'h0);

        // ---- backpressure into skid, then drain ----
        do_reset();
        fetch_rdy = 1'b0;
        set_bus(1'b1); step();
        expect_bus("bp0", 1'b1, 32'h104); expect_out("bp0", 1'b1, 32'h100);
        set_bus(1'b1); step();
        expect_bus("bp1", 1'b0, 32'h0); expect_out("bp1", 1'b1, 32'h100);
        set_bus(1'b0); step();
        expect_bus("bp2", 1'b0, 32'h0); expect_out("bp2", 1'b1, 32'h100);
        fetch_rdy = 1'b1; step();
        expect_bus("bp3", 1'b1, 32'h108); expect_out("bp3", 1'b1, 32'h104);
        step();
        expect_out("bp4", 1'b0, 32'h0);

        // ---- branch during a slow request ----
        do_reset();
        fetch_rdy = 1'b1;
        set_bus(1'b1); step();
        expect_bus("fl0", 1'b1, 32'h104); expect_out("fl0", 1'b1, 32'h100);
        set_bus(1'b0); step();
        expect_bus("fl1", 1'b1, 32'h104);
        branch = 1'b1; branch_target = 32'h203; step();
        branch = 1'b0; branch_target = 32'h0;
        expect_bus("fl2", 1'b1, 32'h104); expect_out("fl2", 1'b0, 32'h0);
        step();
        expect_bus("fl3", 1'b1, 32'h104);
        set_bus(1'b1); step();
        expect_bus("fl4", 1'b1, 32'h200); expect_out("fl4", 1'b0, 32'h0);
        set_bus(1'b0); step();
        expect_out("fl5", 1'b0, 32'h0);
        set_bus(1'b1); step();
        expect_bus("fl6", 1'b1, 32'h204); expect_out("fl6", 1'b1, 32'h200);
        set_bus(1'b0);

        // ---- branch with ack while output is stalled ----
        do_reset();
        fetch_rdy = 1'b1;
        set_bus(1'b1); step();
        expect_out("ba0", 1'b1, 32'h100);
        fetch_rdy = 1'b0; set_bus(1'b1);
        branch = 1'b1; branch_target = 32'h300; step();
        branch = 1'b0;
        expect_bus("ba1", 1'b1, 32'h300); expect_out("ba1", 1'b0, 32'h0);
        set_bus(1'b0); step();
        expect_bus("ba2", 1'b1, 32'h300); expect_out("ba2", 1'b0, 32'h0);
        set_bus(1'b1); step();
        expect_bus("ba3", 1'b1, 32'h304); expect_out("ba3", 1'b1, 32'h300);
        set_bus(1'b0);

        // ---- address wrap at the top of memory ----
        do_reset();
        fetch_rdy = 1'b1;
        set_bus(1'b0); branch = 1'b1; branch_target = 32'hFFFF_FFF9; step();
        branch = 1'b0;
        set_bus(1'b1); step();
        expect_bus("wr0", 1'b1, 32'hFFFF_FFF8);
        set_bus(1'b1); step();
        expect_bus("wr1", 1'b1, 32'hFFFF_FFFC); expect_out("wr1", 1'b1, 32'hFFFF_FFF8);
        set_bus(1'b1); step();
        expect_bus("wr2", 1'b1, 32'h0); expect_out("wr2", 1'b1, 32'hFFFF_FFFC);
        set_bus(1'b0);

        // ---- reset during an open request, late ack afterwards ----
        do_reset();
        fetch_rdy = 1'b1;
        set_bus(1'b0); step();
        rst = 1'b1; #1;
        check("mr_req", {31'd0, instr_req}, 32'd0);
        check("mr_vld", {31'd0, fetch_vld}, 32'd0);
        check("mr_addr", instr_addr, 32'h100);
        step();
        rst = 1'b0; set_bus(1'b1); step();
        expect_bus("mr0", 1'b1, 32'h100); expect_out("mr0", 1'b0, 32'h0);
        set_bus(1'b0); step();
        expect_bus("mr1", 1'b1, 32'h100); expect_out("mr1", 1'b0, 32'h0);

        // ---- randomized run against the stream model ----
        do_reset();
        next_req = 32'h100; redir = 1'b0; exp_pc = 32'h100; deliveries = 0;
        p_req = 1'b0; p_ack = 1'b0; p_vld = 1'b0; p_rdy = 1'b0; p_branch = 1'b0;
        p_addr = 32'h0; p_pc = 32'h0; p_ir = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            // Bus rule: an unacked request stays put.
            if (p_req && !p_ack) begin
                check("rnd_hold_req", {31'd0, instr_req}, 32'd1);
                check("rnd_hold_addr", instr_addr, p_addr);
            end
            // A fresh request goes to the predicted address.
            if (instr_req && (!p_req || p_ack)) begin
                check("rnd_req_addr", instr_addr, next_req);
                redir = 1'b0;
            end
            // Stalled output stays stable unless withdrawn by a branch.
            if (p_vld && !p_rdy && !p_branch) begin
                check("rnd_stable_vld", {31'd0, fetch_vld}, 32'd1);
                check("rnd_stable_pc", fetch_pc, p_pc);
                check("rnd_stable_ir", fetch_ir, p_ir);
            end
            if (p_branch) check("rnd_branch_vld", {31'd0, fetch_vld}, 32'd0);

            r_ack = instr_req && ($urandom_range(0, 2) != 0);
            r_rdy = ($urandom_range(0, 3) != 0);
            r_br  = ($urandom_range(0, 19) == 0);
            r_tgt = $urandom;

            // Delivered instructions form consecutive runs starting at each target.
            if (fetch_vld && r_rdy && !r_br) begin
                check("rnd_deliver_pc", fetch_pc, exp_pc);
                check("rnd_deliver_ir", fetch_ir, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                deliveries++;
            end
            if (instr_req && r_ack && !r_br && !redir) next_req = instr_addr + 32'd4;
            if (r_br) begin
                next_req = r_tgt & ~32'd3;
                exp_pc   = r_tgt & ~32'd3;
                redir    = 1'b1;
            end

            p_req = instr_req; p_addr = instr_addr; p_ack = r_ack;
            p_vld = fetch_vld; p_rdy = r_rdy; p_pc = fetch_pc; p_ir = fetch_ir;
            p_branch = r_br;

            set_bus(r_ack);
            fetch_rdy = r_rdy; branch = r_br; branch_target = r_tgt;
            step();
        end
        check("rnd_progress", {31'd0, deliveries > 200}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
